// File: rtl/mmu_tlbmaint_pkg.sv
// mmu_tlbmaint_pkg: shared types and defaults for the TLB-maintenance responder
package mmu_tlbmaint_pkg;

  typedef enum logic {
    NO_CANCEL      = 1'b0,
    CANCEL_ALLOWED = 1'b1
  } cancel_mode_t;

  typedef enum logic [2:0] {
    OP_READ  = 3'd0,
    OP_WRITE = 3'd1,
    OP_PROBE = 3'd2,
    OP_IDXL  = 3'd3,
    OP_IDXJ  = 3'd4
  } tlb_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_INVAL  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Latched command; the storage commands share their encoding with tlb_op_t
  typedef enum logic [2:0] {
    CMD_READ  = 3'd0,
    CMD_WRITE = 3'd1,
    CMD_PROBE = 3'd2,
    CMD_IDXL  = 3'd3,
    CMD_IDXJ  = 3'd4,
    CMD_INVD  = 3'd5,
    CMD_INVI  = 3'd6
  } cmd_t;

  localparam int LTLB_ENTRIES_D = 8;
  localparam int JTLB_BASE_D    = 64;

  // Index lies in the hole between the LTLB and the JTLB
  function automatic logic idx_bad(input logic [31:0] idx, input logic [31:0] ltlb,
                                   input logic [31:0] jbase);
    return (idx >= ltlb) && (idx < jbase);
  endfunction

  function automatic logic is_inval(input cmd_t c);
    return (c == CMD_INVD) || (c == CMD_INVI);
  endfunction

endpackage

// File: rtl/mmu_tlbmaint_inval_walk.sv
// mmu_tlbmaint_inval_walk: walks the micro-TLB entries, one invalidate pulse per cycle
module mmu_tlbmaint_inval_walk
  import mmu_tlbmaint_pkg::*;
#(
  parameter int UTLB_ENTRIES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_sel_i,
  output logic       o_inv_d,
  output logic       o_inv_i,
  output logic [1:0] o_idx,
  output logic       o_last
);

  localparam logic [1:0] LAST = 2'(UTLB_ENTRIES - 1);

  logic [1:0] r_cnt;

  // Counter runs while walking, parks on the last entry and clears once the walk ends
  always_ff @(posedge clock) begin
    if (!reset) r_cnt <= '0;
    else r_cnt <= !i_en ? 2'd0 : (r_cnt == LAST) ? r_cnt : r_cnt + 2'd1;
  end

  assign o_inv_d = i_en & ~i_sel_i;
  assign o_inv_i = i_en & i_sel_i;
  assign o_idx   = i_en ? r_cnt : 2'd0;
  assign o_last  = i_en & (r_cnt == LAST);

endmodule

// File: rtl/mmu_tlbmaint_ctrl.sv
// mmu_tlbmaint_ctrl: sequences processor TLB-maintenance commands against TLB storage
module mmu_tlbmaint_ctrl
  import mmu_tlbmaint_pkg::*;
#(
  parameter int IDX_W        = 9,
  parameter int LTLB_ENTRIES = LTLB_ENTRIES_D,
  parameter int JTLB_BASE    = JTLB_BASE_D,
  parameter int UTLB_ENTRIES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  cancel_mode_t     cancel_mode_i_m,
  input  logic             cancel_i,
  input  logic             tlbread_i_m,
  input  logic             tlbwrite_i_m,
  input  logic             tlbprobe_i_m,
  input  logic             tlbindexl_i_m,
  input  logic             tlbindexj_i_m,
  input  logic             tlbinvald_i_m,
  input  logic             tlbinvali_i_m,
  output logic             f_stall_mmu_o,
  output logic             rr_stall_mmu_o,
  output logic             mmc_e,
  output logic [IDX_W-1:0] mmc_idx,
  output logic             tlb_req_o,
  output tlb_op_t          tlb_op_o,
  output logic [IDX_W-1:0] tlb_idx_o,
  input  logic             tlb_ack_i,
  input  logic             tlb_hit_i,
  input  logic [IDX_W-1:0] tlb_hit_idx_i,
  output logic             utlb_inv_d_o,
  output logic             utlb_inv_i_o,
  output logic [1:0]       utlb_inv_idx_o
);

  state_t           r_state, w_next, w_go;
  cmd_t             r_cmd, w_cmd, w_cmd_sel;
  logic [6:0]       w_strobes;
  logic             w_any, w_search, w_upd, w_last;
  logic             r_rr_stall, r_f_stall, r_mmc_e;
  logic [IDX_W-1:0] r_mmc_idx;

  assign w_strobes = {tlbinvali_i_m, tlbinvald_i_m, tlbwrite_i_m, tlbread_i_m,
                      tlbprobe_i_m, tlbindexj_i_m, tlbindexl_i_m};
  assign w_any     = |w_strobes;
  assign w_cmd     = tlbinvali_i_m ? CMD_INVI  :
                     tlbinvald_i_m ? CMD_INVD  :
                     tlbwrite_i_m  ? CMD_WRITE :
                     tlbread_i_m   ? CMD_READ  :
                     tlbprobe_i_m  ? CMD_PROBE :
                     tlbindexj_i_m ? CMD_IDXJ  : CMD_IDXL;
  // New strobes only matter in IDLE; elsewhere the latched command rules
  assign w_cmd_sel = (r_state == ST_IDLE) ? w_cmd : r_cmd;
  assign w_go      = is_inval(w_cmd_sel) ? ST_INVAL : ST_ACCESS;
  assign w_search  = (r_cmd == CMD_PROBE) || (r_cmd == CMD_IDXL) || (r_cmd == CMD_IDXJ);
  assign w_upd     = (r_state == ST_ACCESS) && tlb_ack_i;

  // Next-state selection
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   w_next = !w_any ? ST_IDLE : (cancel_mode_i_m == CANCEL_ALLOWED) ? ST_CHECK : w_go;
      ST_CHECK:  w_next = cancel_i ? ST_IDLE : w_go;
      ST_ACCESS: w_next = tlb_ack_i ? ST_DONE : ST_ACCESS;
      ST_INVAL:  w_next = w_last ? ST_DONE : ST_INVAL;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // State, latched command and stalls registered from the upcoming state
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cmd      <= CMD_READ;
      r_rr_stall <= 1'b0;
      r_f_stall  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cmd      <= w_cmd_sel;
      r_rr_stall <= (w_next == ST_CHECK) || (w_next == ST_ACCESS) || (w_next == ST_INVAL);
      r_f_stall  <= ((w_next == ST_ACCESS) && (w_cmd_sel == CMD_WRITE)) ||
                    ((w_next == ST_INVAL) && (w_cmd_sel == CMD_INVI));
    end
  end

  // MMC error bit and index, updated only when the storage acknowledges
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_mmc_e   <= 1'b0;
      r_mmc_idx <= '0;
    end else if (w_upd) begin
      r_mmc_e   <= w_search ? !tlb_hit_i :
                   (r_cmd == CMD_WRITE) && idx_bad(32'(r_mmc_idx), 32'(LTLB_ENTRIES), 32'(JTLB_BASE));
      r_mmc_idx <= (w_search && tlb_hit_i) ? tlb_hit_idx_i : r_mmc_idx;
    end
  end

  mmu_tlbmaint_inval_walk #(
    .UTLB_ENTRIES(UTLB_ENTRIES)
  ) u_walk (
    .clock   (clock),
    .reset   (reset),
    .i_en    (r_state == ST_INVAL),
    .i_sel_i (r_cmd == CMD_INVI),
    .o_inv_d (utlb_inv_d_o),
    .o_inv_i (utlb_inv_i_o),
    .o_idx   (utlb_inv_idx_o),
    .o_last  (w_last)
  );

  assign tlb_req_o      = (r_state == ST_ACCESS);
  assign tlb_op_o       = tlb_req_o ? tlb_op_t'(r_cmd) : OP_READ;
  assign tlb_idx_o      = !tlb_req_o ? '0 :
                          ((r_cmd == CMD_READ) || (r_cmd == CMD_WRITE)) ? r_mmc_idx :
                          (r_cmd == CMD_IDXJ) ? IDX_W'(JTLB_BASE) : '0;
  assign rr_stall_mmu_o = r_rr_stall;
  assign f_stall_mmu_o  = r_f_stall;
  assign mmc_e          = r_mmc_e;
  assign mmc_idx        = r_mmc_idx;

  a_one_strobe: assert property (@(posedge clock) disable iff (!reset) $onehot0(w_strobes));

endmodule

// File: tb/tb_mmu_tlbmaint_ctrl.sv
// tb_mmu_tlbmaint_ctrl: directed self-checking bench for the TLB-maintenance responder
module tb_mmu_tlbmaint_ctrl;
  import mmu_tlbmaint_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  cancel_mode_t cm = NO_CANCEL;
  logic         cancel_i = 1'b0;
  logic         rd = 1'b0, wr = 1'b0, pr = 1'b0, il = 1'b0, ij = 1'b0, id = 1'b0, ii = 1'b0;
  logic         tlb_ack_i = 1'b0, tlb_hit_i = 1'b0;
  logic [8:0]   tlb_hit_idx_i = '0;
  logic         f_stall, rr_stall, mmc_e, tlb_req_o, inv_d, inv_i;
  logic [8:0]   mmc_idx, tlb_idx_o;
  tlb_op_t      tlb_op_o;
  logic [1:0]   inv_idx;
  int           n_tot = 0, n_bad = 0;
  int           bidx[5] = '{20, 8, 7, 63, 64};
  logic         be[5]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  mmu_tlbmaint_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .cancel_mode_i_m (cm),
    .cancel_i        (cancel_i),
    .tlbread_i_m     (rd),
    .tlbwrite_i_m    (wr),
    .tlbprobe_i_m    (pr),
    .tlbindexl_i_m   (il),
    .tlbindexj_i_m   (ij),
    .tlbinvald_i_m   (id),
    .tlbinvali_i_m   (ii),
    .f_stall_mmu_o   (f_stall),
    .rr_stall_mmu_o  (rr_stall),
    .mmc_e           (mmc_e),
    .mmc_idx         (mmc_idx),
    .tlb_req_o       (tlb_req_o),
    .tlb_op_o        (tlb_op_o),
    .tlb_idx_o       (tlb_idx_o),
    .tlb_ack_i       (tlb_ack_i),
    .tlb_hit_i       (tlb_hit_i),
    .tlb_hit_idx_i   (tlb_hit_idx_i),
    .utlb_inv_d_o    (inv_d),
    .utlb_inv_i_o    (inv_i),
    .utlb_inv_idx_o  (inv_idx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Codes: 0 read, 1 write, 2 probe, 3 indexl, 4 indexj, 5 invald, 6 invali
  task automatic strobe(input int c);
    rd = (c == 0); wr = (c == 1); pr = (c == 2); il = (c == 3);
    ij = (c == 4); id = (c == 5); ii = (c == 6);
  endtask

  task automatic clr();
    {rd, wr, pr, il, ij, id, ii} = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rr"}, 32'(rr_stall), 0);
    chk({tag, "_f"}, 32'(f_stall), 0);
    chk({tag, "_req"}, 32'(tlb_req_o), 0);
    chk({tag, "_op"}, 32'(tlb_op_o), 0);
    chk({tag, "_tidx"}, 32'(tlb_idx_o), 0);
    chk({tag, "_invd"}, 32'(inv_d), 0);
    chk({tag, "_invi"}, 32'(inv_i), 0);
    chk({tag, "_invidx"}, 32'(inv_idx), 0);
  endtask

  // NO_CANCEL storage command, acked in the lat-th ACCESS cycle; ends back in IDLE
  task automatic acc(input int c, input int lat, input logic hit, input logic [8:0] hidx,
                     input logic [8:0] exp_tidx);
    cm = NO_CANCEL;
    strobe(c);
    tick();
    clr();
    for (int i = 0; i < lat; i++) begin
      chk("acc_req", 32'(tlb_req_o), 1);
      chk("acc_op", 32'(tlb_op_o), 32'(c));
      chk("acc_tidx", 32'(tlb_idx_o), 32'(exp_tidx));
      chk("acc_rr", 32'(rr_stall), 1);
      chk("acc_f", 32'(f_stall), 32'(c == 1));
      if (i == lat - 1) begin
        tlb_ack_i = 1'b1; tlb_hit_i = hit; tlb_hit_idx_i = hidx;
      end
      tick();
    end
    tlb_ack_i = 1'b0; tlb_hit_i = 1'b0; tlb_hit_idx_i = '0;
    chk("done_rr", 32'(rr_stall), 0);
    chk("done_f", 32'(f_stall), 0);
    chk("done_req", 32'(tlb_req_o), 0);
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk_idle("rst");
    chk("rst_e", 32'(mmc_e), 0);
    chk("rst_idx", 32'(mmc_idx), 0);
    reset = 1'b1;
    tick();

    acc(2, 3, 1'b1, 9'd70, 9'd0);
    chk("probe_idx", 32'(mmc_idx), 70);
    chk("probe_e", 32'(mmc_e), 0);

    cm = CANCEL_ALLOWED;
    strobe(1);
    tick();
    clr();
    chk("cx_rr", 32'(rr_stall), 1);
    chk("cx_req", 32'(tlb_req_o), 0);
    chk("cx_f", 32'(f_stall), 0);
    cancel_i = 1'b1;
    tick();
    cancel_i = 1'b0;
    chk("cx_rr2", 32'(rr_stall), 0);
    chk("cx_req2", 32'(tlb_req_o), 0);
    tick();
    chk("cx_req3", 32'(tlb_req_o), 0);
    chk("cx_idx", 32'(mmc_idx), 70);
    chk("cx_e", 32'(mmc_e), 0);
    cm = NO_CANCEL;

    for (int k = 0; k < 5; k++) begin
      acc(2, 1, 1'b1, 9'(bidx[k]), 9'd0);
      chk("wr_pre_e", 32'(mmc_e), 0);
      acc(1, 2, 1'b0, 9'd0, 9'(bidx[k]));
      chk("wr_e", 32'(mmc_e), 32'(be[k]));
      chk("wr_idx", 32'(mmc_idx), 32'(bidx[k]));
    end

    acc(4, 2, 1'b0, 9'd5, 9'd64);
    chk("ij_e", 32'(mmc_e), 1);
    chk("ij_idx", 32'(mmc_idx), 64);
    acc(0, 1, 1'b1, 9'd9, 9'd64);
    chk("rd_e", 32'(mmc_e), 0);
    chk("rd_idx", 32'(mmc_idx), 64);
    acc(3, 1, 1'b1, 9'd3, 9'd0);
    chk("il_idx", 32'(mmc_idx), 3);
    chk("il_e", 32'(mmc_e), 0);

    strobe(6);
    tick();
    clr();
    for (int k = 0; k < 4; k++) begin
      chk("ii_pulse", 32'(inv_i), 1);
      chk("ii_d", 32'(inv_d), 0);
      chk("ii_idx", 32'(inv_idx), 32'(k));
      chk("ii_rr", 32'(rr_stall), 1);
      chk("ii_f", 32'(f_stall), 1);
      chk("ii_req", 32'(tlb_req_o), 0);
      tick();
    end
    chk("ii_done_i", 32'(inv_i), 0);
    chk("ii_done_rr", 32'(rr_stall), 0);
    chk("ii_done_f", 32'(f_stall), 0);
    tick();

    cm = CANCEL_ALLOWED;
    strobe(5);
    tick();
    clr();
    chk("id_chk_rr", 32'(rr_stall), 1);
    chk("id_chk_d", 32'(inv_d), 0);
    chk("id_chk_f", 32'(f_stall), 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("id_pulse", 32'(inv_d), 1);
      chk("id_i", 32'(inv_i), 0);
      chk("id_idx", 32'(inv_idx), 32'(k));
      chk("id_rr", 32'(rr_stall), 1);
      chk("id_f", 32'(f_stall), 0);
      tick();
    end
    chk("id_done_d", 32'(inv_d), 0);
    chk("id_done_rr", 32'(rr_stall), 0);
    tick();
    chk("id_mmc_idx", 32'(mmc_idx), 3);
    chk("id_mmc_e", 32'(mmc_e), 0);
    cm = NO_CANCEL;

    strobe(2);
    tick();
    clr();
    chk("ra_req", 32'(tlb_req_o), 1);
    tlb_ack_i = 1'b1; tlb_hit_i = 1'b1; tlb_hit_idx_i = 9'd100;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tlb_ack_i = 1'b0; tlb_hit_i = 1'b0; tlb_hit_idx_i = '0;
    chk_idle("ra");
    chk("ra_idx", 32'(mmc_idx), 0);
    chk("ra_e", 32'(mmc_e), 0);
    tick();
    chk("ra2_req", 32'(tlb_req_o), 0);
    chk("ra2_rr", 32'(rr_stall), 0);
    chk("ra2_idx", 32'(mmc_idx), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/mmu_tlbmaint_ctrl.md
Name: mmu_tlbmaint_ctrl

Overview:
MMU-side responder for the processor TLB-maintenance interface. It accepts one-hot maintenance commands issued in the processor M stage and honours the cancel mode. It sequences each command against the TLB storage through a request/acknowledge port, drives the fetch and register-read stalls back to the processor, and owns the MMC error bit and index field. It sits between the core pipeline and the LTLB/JTLB/micro-TLB arrays.

Parameters:
IDX_W, 9, width of the MMC index and TLB storage index
LTLB_ENTRIES, 8, LTLB entry count; LTLB indices are 0..LTLB_ENTRIES-1
JTLB_BASE, 64, first JTLB index in the unified index space
UTLB_ENTRIES, 4, micro-TLB entries walked per invalidate

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-low reset
cancel_mode_i_m  in  1  cancel_mode_t: NO_CANCEL=0, CANCEL_ALLOWED=1
cancel_i  in  1  W-stage cancel; sampled only in CHECK
tlbread_i_m  in  1  read entry mmc_idx
tlbwrite_i_m  in  1  write entry mmc_idx
tlbprobe_i_m  in  1  associative search
tlbindexl_i_m  in  1  compute LTLB index
tlbindexj_i_m  in  1  compute JTLB index
tlbinvald_i_m  in  1  invalidate data micro-TLB
tlbinvali_i_m  in  1  invalidate instruction micro-TLB
f_stall_mmu_o  out  1  stall fetch
rr_stall_mmu_o  out  1  stall register read
mmc_e  out  1  MMC error bit
mmc_idx  out  IDX_W  MMC index field
tlb_req_o  out  1  storage request
tlb_op_o  out  3  tlb_op_t
tlb_idx_o  out  IDX_W  storage index
tlb_ack_i  in  1  storage done; 1..N cycles after tlb_req_o
tlb_hit_i  in  1  search hit, valid with tlb_ack_i
tlb_hit_idx_i  in  IDX_W  matching index, valid with tlb_ack_i
utlb_inv_d_o  out  1  invalidate D micro-TLB entry utlb_inv_idx_o
utlb_inv_i_o  out  1  invalidate I micro-TLB entry utlb_inv_idx_o
utlb_inv_idx_o  out  2  micro-TLB entry index

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE. All outputs are 0, including mmc_idx, mmc_e and the walk counter. Reset mid-operation aborts at that edge with no further side effects. A pending tlb_ack_i is ignored after reset.
- FSM states: IDLE, CHECK, ACCESS, INVAL, DONE.
- IDLE, no strobe: outputs idle.
- IDLE, strobe with CANCEL_ALLOWED: latch the command and go to CHECK.
- IDLE, strobe with NO_CANCEL: go directly to ACCESS, or to INVAL for invald/invali.
- Strobe priority if several are set (illegal; flagged by an assertion): invali > invald > write > read > probe > indexj > indexl. Strobes arriving outside IDLE are ignored.
- CHECK (1 cycle): if cancel_i=1, return to IDLE with no state change. Otherwise go to ACCESS or INVAL.
- ACCESS: hold tlb_req_o=1 with tlb_op_o and tlb_idx_o stable until tlb_ack_i, then go to DONE.
  - read/write: tlb_idx_o=mmc_idx.
  - probe: search the whole TLB.
  - indexl: search LTLB only.
  - indexj: search JTLB only.
- On ack of a search op (probe, indexl, indexj):
  - hit: mmc_idx<=tlb_hit_idx_i, mmc_e<=0.
  - miss: mmc_e<=1, mmc_idx unchanged.
- On ack of a write: mmc_e<=1 if mmc_idx is out of range (index >= LTLB_ENTRIES and < JTLB_BASE); the storage discards the write. Otherwise mmc_e<=0.
- On ack of a read: mmc_e<=0.
- INVAL: 2-bit counter from 0. Pulse utlb_inv_d_o or utlb_inv_i_o with utlb_inv_idx_o=counter for one cycle each, for UTLB_ENTRIES cycles. The counter stops at UTLB_ENTRIES-1 and does not wrap. Then go to DONE. mmc_e and mmc_idx are unchanged.
- DONE (1 cycle): stalls drop. Return to IDLE on the next edge.
- rr_stall_mmu_o=1 in CHECK, ACCESS and INVAL.
- f_stall_mmu_o=1 in INVAL for invali and in ACCESS for write. It is 0 otherwise.
- Stalls are registered outputs, asserted the cycle after the strobe.

Decomposition:
- Shared package mmu_tlbmaint_pkg holds:
  - cancel_mode_t (moved out of the interface file);
  - tlb_op_t: OP_READ=0, OP_WRITE=1, OP_PROBE=2, OP_IDXL=3, OP_IDXJ=4;
  - the state enum;
  - LTLB_ENTRIES and JTLB_BASE defaults.
- One sub-module, mmu_tlbmaint_inval_walk (counter plus pulse generator for the INVAL sequence).

Test Plan:
- NO_CANCEL tlbprobe. Strobe at cycle 0, tlb_ack_i with hit=1 and hit_idx=70 at cycle 3 -> mmc_idx=70 and mmc_e=0 at cycle 4; rr_stall high cycles 1-3.
- CANCEL_ALLOWED tlbwrite with cancel_i=1 in CHECK -> no tlb_req_o, mmc unchanged, rr_stall high exactly 1 cycle.
- tlbwrite with mmc_idx=20, LTLB_ENTRIES=8, JTLB_BASE=64 -> mmc_e=1 after ack; f_stall high during ACCESS.
- tlbinvali -> utlb_inv_i_o pulses with idx 0,1,2,3 on 4 consecutive cycles, then DONE; f_stall and rr_stall high throughout; utlb_inv_d_o stays 0.
- reset=0 in ACCESS with ack at the same edge -> IDLE, all outputs 0, mmc_idx=0.
- tlbindexj miss (hit=0) -> mmc_e=1, mmc_idx unchanged. A following tlbread hit -> mmc_e=0.
